uart_rx_frame: RTL and testbench
================================

# uart_rx_frame

Parametrised UART receiver, the successor to the fixed 8-bit receiver. It adds configurable data width, stop-bit count and oversampling, and samples every bit at mid-bit. It has a 2-flop input synchroniser, a synchronous reset, explicit parity and framing error reporting, and break/framing-error recovery. It sits between the serial pin and the byte-consumer logic; downstream logic sees one `valid` pulse per frame.

## Interface
- `CLKS_PER_BIT`, default 16: clock frequency / baud rate. Legal range 4..255.
- `DATA_BITS`, default 8: data bits per frame. Legal range 5..9.
- `STOP_BITS`, default 1: stop bits per frame. Legal values 1 or 2.
- `PARITY_ODD`, default 0: 0 selects even parity, 1 selects odd. Used only when `UART_RX_PARITY_EN` is defined.
- `clock`  in  1  sole clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `data_in`  in  1  asynchronous serial line; idles high.
- `data_out`  out  DATA_BITS  last received word, LSB = first bit on the line.
- `valid`  out  1  one-cycle pulse; `data_out` and both error flags are updated in this cycle.
- `parity_error`  out  1  parity mismatch in the last frame; held until the next `valid`.
- `frame_error`  out  1  a stop bit sampled low in the last frame; held until the next `valid`.
- `busy`  out  1  high in every state except IDLE.

## Operation
- Synchroniser: `data_in` passes through 2 flops (reset value 1). The FSM sees only the synchronised value `rx_s`.
- `HALF = CLKS_PER_BIT/2` (integer division). Bit counter width = clog2(CLKS_PER_BIT). Bit index width = clog2(DATA_BITS+1).
- States:
  - IDLE: on `rx_s==0`, clear the counter and go to START.
  - START: count up. At `cnt==HALF-1`, sample the line. If `rx_s==0`, clear the counter and the bit index and go to DATA. Otherwise treat it as a glitch and return to IDLE with no flags changed. All later samples therefore land at mid-bit.
  - DATA: count 0..CLKS_PER_BIT-1. At `cnt==CLKS_PER_BIT-1`, store `rx_s` in shift bit [index] and clear the counter. After DATA_BITS samples, go to PARITY (macro defined) or STOP.
  - PARITY: one sample at `cnt==CLKS_PER_BIT-1`. Expected bit = XOR of data bits (even) or its inverse (odd). A mismatch sets an internal parity flag. The frame is still completed.
  - STOP: STOP_BITS samples, each at `cnt==CLKS_PER_BIT-1`. Any sample at 0 sets the internal frame flag. After the last sample, go to DONE.
  - DONE: one cycle. Drive `valid`=1, load `data_out`, `parity_error` and `frame_error`. If the frame flag is set, go to RECOVER; otherwise go to IDLE.
  - RECOVER: wait until `rx_s==1` (break or stuck-low line), then go to IDLE. A new start bit is never detected while the line has not yet returned high.
- Undefined state encodings go to IDLE.

## Timing
- Reset values: state IDLE, `data_out`=0, `valid`=0, `parity_error`=0, `frame_error`=0, `busy`=0, synchroniser=1, all counters 0.
- Reset asserted mid-frame: the frame is abandoned and no `valid` is produced. Reception restarts with the first falling edge after reset deasserts.
- Pin-to-detection delay: 2 cycles from a pin transition to the change in `rx_s`.
- Let t0 be the cycle in which IDLE first sees `rx_s==0`, and N = DATA_BITS + P + STOP_BITS, where P=1 with the macro defined and 0 without.
  - Start sample at t0+HALF.
  - Bit k (k=1..N) sampled at t0+HALF+k·CLKS_PER_BIT.
  - `valid` high exactly in cycle t0+HALF+N·CLKS_PER_BIT+1.
- Back-to-back frames: IDLE is reached the cycle after DONE, with no dead bit required. The minimum frame spacing is therefore the nominal frame length.
- `valid` never asserts for two consecutive cycles.

## Configuration
- `UART_RX_PARITY_EN`
  - Defined: the PARITY state exists, frames carry 1 parity bit, and `parity_error` is functional.
  - Undefined: the PARITY state and parity logic are removed, frames carry no parity bit, `parity_error` is tied to 0, and `PARITY_ODD` is ignored.

## Test plan
- Macro on, CLKS_PER_BIT=4, 8E1. Send 0xA5 with parity 0 → `valid` at t0+43, `data_out`=0xA5, both error flags 0.
- Same setup, send 0xA5 with parity 1 → `valid` pulse, `data_out`=0xA5, `parity_error`=1, `frame_error`=0. Next good frame 0x3C → `parity_error` returns to 0.
- Stop bit driven low, line held low 30 cycles, then high, then frame 0x55 → first `valid` has `frame_error`=1. No spurious start during the low period. Second `valid` has `data_out`=0x55 and `frame_error`=0.
- Low glitch of 1 bit-period/4 on an idle line → no `valid`; `busy` returns to 0 within HALF+3 cycles.
- Macro off, DATA_BITS=7, STOP_BITS=2, CLKS_PER_BIT=16. Send 0x41 then 0x7F back to back → two `valid` pulses 160 cycles apart with correct data. Second stop bit low in a third frame → `frame_error`=1.
- Assert `reset` for 1 cycle mid-DATA → no `valid`, all outputs 0. A frame sent afterwards is received correctly.

Source files
------------

// File: rtl/uart_rx_frame.sv
// Parametrised mid-bit-sampling UART receiver with 2-flop synchroniser, parity/framing errors and break recovery.
// Optional parity bit support is enabled by defining UART_RX_PARITY_EN.
module uart_rx_frame #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8,
    parameter int STOP_BITS    = 1,
    parameter int PARITY_ODD   = 0
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 data_in,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 valid,
    output logic                 parity_error,
    output logic                 frame_error,
    output logic                 busy
);

    localparam int HALF  = CLKS_PER_BIT / 2;
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(DATA_BITS + 1);

    localparam logic [CNT_W-1:0] CNT_HALF_M1 = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [IDX_W-1:0] IDX_LAST    = IDX_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0] IDX_ONE     = IDX_W'(1);
    localparam logic             STOP_LAST   = 1'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_START   = 3'd1,
        ST_DATA    = 3'd2,
`ifdef UART_RX_PARITY_EN
        ST_PARITY  = 3'd3,
`endif
        ST_STOP    = 3'd4,
        ST_DONE    = 3'd5,
        ST_RECOVER = 3'd6
    } state_t;

`ifdef UART_RX_PARITY_EN
    localparam logic PAR_SENSE = 1'(PARITY_ODD);

    // Expected parity bit: XOR of the data word, inverted for odd parity.
    function automatic logic expected_parity(input logic [DATA_BITS-1:0] word);
        return (^word) ^ PAR_SENSE;
    endfunction

    logic                 parity_flag_r;
`endif

    state_t               state_r;
    logic [1:0]           sync_r;
    logic                 rx_s;
    logic [CNT_W-1:0]     cnt_r;
    logic [IDX_W-1:0]     idx_r;
    logic                 stop_idx_r;
    logic                 frame_flag_r;
    logic [DATA_BITS-1:0] shift_r;

    assign rx_s = sync_r[1];

    // Two-flop synchroniser for the asynchronous serial line; idles high.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync_r <= 2'b11;
        end else begin
            sync_r <= {sync_r[0], data_in};
        end
    end

    // Receive FSM with registered outputs; valid is set on the last stop sample so it is high during DONE.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r       <= ST_IDLE;
            cnt_r         <= '0;
            idx_r         <= '0;
            stop_idx_r    <= 1'b0;
            frame_flag_r  <= 1'b0;
            shift_r       <= '0;
            data_out      <= '0;
            valid         <= 1'b0;
            parity_error  <= 1'b0;
            frame_error   <= 1'b0;
            busy          <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_flag_r <= 1'b0;
`endif
        end else begin
            valid <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (!rx_s) begin
                        cnt_r   <= '0;
                        state_r <= ST_START;
                        busy    <= 1'b1;
                    end
                end
                ST_START: begin
                    if (cnt_r == CNT_HALF_M1) begin
                        if (!rx_s) begin
                            cnt_r        <= '0;
                            idx_r        <= '0;
                            stop_idx_r   <= 1'b0;
                            frame_flag_r <= 1'b0;
`ifdef UART_RX_PARITY_EN
                            parity_flag_r <= 1'b0;
`endif
                            state_r      <= ST_DATA;
                        end else begin
                            state_r <= ST_IDLE;
                            busy    <= 1'b0;
                        end
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                ST_DATA: begin
                    if (cnt_r == CNT_LAST) begin
                        cnt_r   <= '0;
                        // Shifting in from the top leaves the first line bit in the LSB.
                        shift_r <= {rx_s, shift_r[DATA_BITS-1:1]};
                        if (idx_r == IDX_LAST) begin
                            idx_r <= '0;
`ifdef UART_RX_PARITY_EN
                            state_r <= ST_PARITY;
`else
                            state_r <= ST_STOP;
`endif
                        end else begin
                            idx_r <= idx_r + IDX_ONE;
                        end
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
`ifdef UART_RX_PARITY_EN
                ST_PARITY: begin
                    if (cnt_r == CNT_LAST) begin
                        cnt_r         <= '0;
                        parity_flag_r <= (rx_s != expected_parity(shift_r));
                        state_r       <= ST_STOP;
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
`endif
                ST_STOP: begin
                    if (cnt_r == CNT_LAST) begin
                        cnt_r        <= '0;
                        frame_flag_r <= frame_flag_r | ~rx_s;
                        if (stop_idx_r == STOP_LAST) begin
                            valid       <= 1'b1;
                            data_out    <= shift_r;
                            frame_error <= frame_flag_r | ~rx_s;
`ifdef UART_RX_PARITY_EN
                            parity_error <= parity_flag_r;
`else
                            parity_error <= 1'b0;
`endif
                            state_r     <= ST_DONE;
                        end else begin
                            stop_idx_r <= 1'b1;
                        end
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                ST_DONE: begin
                    // A low stop bit may be a break; wait for the line to go high before hunting again.
                    if (frame_flag_r) begin
                        state_r <= ST_RECOVER;
                    end else begin
                        state_r <= ST_IDLE;
                        busy    <= 1'b0;
                    end
                end
                ST_RECOVER: begin
                    if (rx_s) begin
                        state_r <= ST_IDLE;
                        busy    <= 1'b0;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    cnt_r   <= '0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_frame.sv
// Directed bench for uart_rx_frame: an 8-bit/1-stop instance at 4 clocks/bit and a 7-bit/2-stop instance at 16.
module tb_uart_rx_frame;

`ifdef UART_RX_PARITY_EN
    localparam int PEN = 1;
`else
    localparam int PEN = 0;
`endif
    localparam logic PEN_B  = 1'(PEN);
    localparam int LAT_A    = 2 + 2 + (8 + PEN + 1) * 4 + 1;
    localparam int LAT_B    = 2 + 8 + (7 + PEN + 2) * 16 + 1;
    localparam int SPACE_B  = (1 + 7 + PEN + 2) * 16;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       line_a = 1'b1;
    logic       line_b = 1'b1;
    logic [7:0] data_out_a;
    logic [6:0] data_out_b;
    logic       valid_a, parity_error_a, frame_error_a, busy_a;
    logic       valid_b, parity_error_b, frame_error_b, busy_b;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int dbl   = 0;
    logic prev_a = 1'b0;
    logic prev_b = 1'b0;

    typedef struct { logic [8:0] d; logic pe; logic fe; int c; } rec_t;
    rec_t qa[$];
    rec_t qb[$];

    typedef struct { logic [7:0] d; logic flip; logic [7:0] exp_d; logic exp_pe; logic exp_fe; } vec_t;
    vec_t vecs[5];

    uart_rx_frame #(.CLKS_PER_BIT(4), .DATA_BITS(8), .STOP_BITS(1), .PARITY_ODD(0)) dut_a (
        .clock(clock), .reset(reset), .data_in(line_a), .data_out(data_out_a),
        .valid(valid_a), .parity_error(parity_error_a), .frame_error(frame_error_a), .busy(busy_a)
    );

    uart_rx_frame #(.CLKS_PER_BIT(16), .DATA_BITS(7), .STOP_BITS(2), .PARITY_ODD(0)) dut_b (
        .clock(clock), .reset(reset), .data_in(line_b), .data_out(data_out_b),
        .valid(valid_b), .parity_error(parity_error_b), .frame_error(frame_error_b), .busy(busy_b)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Record every valid pulse with its cycle stamp; flag back-to-back valid cycles.
    always @(negedge clock) begin
        if (valid_a) qa.push_back('{9'(data_out_a), parity_error_a, frame_error_a, cyc});
        if (valid_b) qb.push_back('{9'(data_out_b), parity_error_b, frame_error_b, cyc});
        if ((valid_a && prev_a) || (valid_b && prev_b)) dbl = dbl + 1;
        prev_a = valid_a;
        prev_b = valid_b;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic hold(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic drive(input int sel, input logic v);
        if (sel == 0) line_a = v;
        else          line_b = v;
    endtask

    // Drive one frame starting at the current negedge; c0 is the cycle stamp of the start-bit edge.
    task automatic send(input int sel, input int cpb, input int nb, input logic [8:0] d,
                        input logic par, input int ns, input logic [1:0] stops, output int c0);
        c0 = cyc;
        drive(sel, 1'b0);
        hold(cpb);
        for (int i = 0; i < nb; i++) begin
            drive(sel, d[i]);
            hold(cpb);
        end
        if (PEN_B) begin
            drive(sel, par);
            hold(cpb);
        end
        for (int i = 0; i < ns; i++) begin
            drive(sel, stops[i]);
            hold(cpb);
        end
        drive(sel, 1'b1);
    endtask

    initial begin
        int   c0;
        int   c1;
        rec_t r;
        rec_t r2;

        vecs[0] = '{8'hA5, 1'b0, 8'hA5, 1'b0,  1'b0};
        vecs[1] = '{8'hA5, 1'b1, 8'hA5, PEN_B, 1'b0};
        vecs[2] = '{8'h3C, 1'b0, 8'h3C, 1'b0,  1'b0};
        vecs[3] = '{8'h00, 1'b0, 8'h00, 1'b0,  1'b0};
        vecs[4] = '{8'hFF, 1'b1, 8'hFF, PEN_B, 1'b0};

        hold(3);
        check("rst_data", 32'(data_out_a), 32'h0);
        check("rst_valid", 32'(valid_a), 32'h0);
        check("rst_perr", 32'(parity_error_a), 32'h0);
        check("rst_ferr", 32'(frame_error_a), 32'h0);
        check("rst_busy", 32'({busy_a, busy_b}), 32'h0);
        reset = 1'b0;
        hold(5);

        // Table-driven frames on instance A: data, parity error flag, latency.
        for (int i = 0; i < 5; i++) begin
            send(0, 4, 8, {1'b0, vecs[i].d}, (^vecs[i].d) ^ vecs[i].flip, 1, 2'b11, c0);
            hold(8);
            check("vec_count", 32'(qa.size()), 32'h1);
            if (qa.size() > 0) begin
                r = qa.pop_front();
                check("vec_data", 32'(r.d), 32'(vecs[i].exp_d));
                check("vec_perr", 32'(r.pe), 32'(vecs[i].exp_pe));
                check("vec_ferr", 32'(r.fe), 32'(vecs[i].exp_fe));
                check("vec_latency", 32'(r.c - c0), 32'(LAT_A));
            end
            qa.delete();
        end

        // One-cycle low glitch on an idle line is rejected at the start-bit sample.
        c0 = cyc;
        drive(0, 1'b0);
        hold(1);
        drive(0, 1'b1);
        hold(3);
        check("glitch_busy_hi", 32'(busy_a), 32'h1);
        hold(3);
        check("glitch_busy_lo", 32'(busy_a), 32'h0);
        hold(20);
        check("glitch_novalid", 32'(qa.size()), 32'h0);
        qa.delete();

        // Low stop bit followed by a held-low line, then a clean frame.
        send(0, 4, 8, 9'h05A, ^8'h5A, 1, 2'b00, c0);
        drive(0, 1'b0);
        hold(30);
        drive(0, 1'b1);
        hold(6);
        send(0, 4, 8, 9'h055, ^8'h55, 1, 2'b11, c1);
        hold(10);
        check("brk_count", 32'(qa.size()), 32'h2);
        if (qa.size() == 2) begin
            r  = qa.pop_front();
            r2 = qa.pop_front();
            check("brk_ferr", 32'(r.fe), 32'h1);
            check("brk_data", 32'(r.d), 32'h5A);
            check("brk_next_data", 32'(r2.d), 32'h55);
            check("brk_next_ferr", 32'(r2.fe), 32'h0);
            check("brk_next_lat", 32'(r2.c - c1), 32'(LAT_A));
        end
        qa.delete();

        // One-cycle reset during the data phase abandons the frame.
        fork
            send(0, 4, 8, 9'h0FE, ^8'hFE, 1, 2'b11, c0);
            begin
                hold(6);
                reset = 1'b1;
                hold(1);
                check("mid_rst_data", 32'(data_out_a), 32'h0);
                check("mid_rst_flags", 32'({valid_a, parity_error_a, frame_error_a, busy_a}), 32'h0);
                reset = 1'b0;
            end
        join
        hold(30);
        check("mid_rst_novalid", 32'(qa.size()), 32'h0);
        qa.delete();
        send(0, 4, 8, 9'h096, ^8'h96, 1, 2'b11, c0);
        hold(8);
        check("post_rst_count", 32'(qa.size()), 32'h1);
        if (qa.size() > 0) begin
            r = qa.pop_front();
            check("post_rst_data", 32'(r.d), 32'h96);
        end
        qa.delete();

        // Instance B: back-to-back frames, then a low second stop bit.
        send(1, 16, 7, 9'h041, ^7'h41, 2, 2'b11, c0);
        send(1, 16, 7, 9'h07F, ^7'h7F, 2, 2'b11, c1);
        hold(20);
        check("b2b_count", 32'(qb.size()), 32'h2);
        if (qb.size() == 2) begin
            r  = qb.pop_front();
            r2 = qb.pop_front();
            check("b2b_data0", 32'(r.d), 32'h41);
            check("b2b_data1", 32'(r2.d), 32'h7F);
            check("b2b_lat0", 32'(r.c - c0), 32'(LAT_B));
            check("b2b_spacing", 32'(r2.c - r.c), 32'(SPACE_B));
            check("b2b_ferr", 32'({r.fe, r2.fe}), 32'h0);
        end
        qb.delete();
        send(1, 16, 7, 9'h02A, ^7'h2A, 2, 2'b01, c0);
        hold(20);
        check("stop2_count", 32'(qb.size()), 32'h1);
        if (qb.size() > 0) begin
            r = qb.pop_front();
            check("stop2_ferr", 32'(r.fe), 32'h1);
            check("stop2_data", 32'(r.d), 32'h2A);
        end
        check("no_double_valid", 32'(dbl), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
